io_input_bank: RTL

//  Parametrised memory-mapped input block for the single-cycle CPU I/O space: N switch ports, each

---
 rtl/io_input_bank_if.sv | 13 +
 rtl/io_input_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/io_input_bank_if.sv
// io_input_bank_if: CPU data-memory read bus seen by the input bank.
//   addr    : CPU data address (only [7:2] decoded by the bank)
//   rd      : read strobe, qualifies clear-on-read of the status word
//   io_data : registered read data returned by the bank
// master = CPU side, slave = io_input_bank side.
interface io_input_bank_if;
  logic [31:0] addr;
  logic        rd;
  logic [31:0] io_data;

  modport master (output addr, output rd, input io_data);
  modport slave  (input addr, input rd, output io_data);
endinterface

// File: rtl/io_input_bank.sv
// io_input_bank: memory-mapped switch input bank for the CPU I/O space.
//   Each port is synchronised, debounced and latched into a stable register
//   readable at addr[7:2] = BASE_IDX+i. A sticky change word (clear-on-read) sits
//   at BASE_IDX+N_PORTS. A round-robin double-dabble engine refreshes DIGITS
//   seven-segment digits per port.
// Ports:
//   io_clk, resetn : clock, async active-low reset
//   bus (slave)    : addr / rd in, registered io_data out
//   in_port        : raw switches, port i at [i*PORT_W +: PORT_W]
//   dt             : segments, port i digit d at [(i*DIGITS+d)*7 +: 7], bit0=a..bit6=g
//   bcd_busy       : conversion in progress
//   io_irq         : only when IO_IN_IRQ_EN is defined; registered |change

// Per-port synchroniser + debouncer.
module io_input_bank_lane #(
  parameter int W   = 5,
  parameter int DEB = 4
) (
  input  logic         io_clk,
  input  logic         resetn,
  input  logic [W-1:0] i_raw,
  output logic [W-1:0] o_stable,
  output logic         o_set
);
  localparam int CW = $clog2(DEB + 1);

  logic [W-1:0]  r_s1, r_s2, r_last, r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_accept;

  // Accept once the synchronised value has been seen DEB times in a row.
  assign w_accept = (r_cnt == CW'(DEB - 1)) && (r_s2 == r_last) && (r_s2 != r_stable);

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_last   <= '0;
      r_stable <= '0;
      r_cnt    <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_last <= r_s2;
      if (r_s2 != r_last)               r_cnt <= '0;
      else if (r_cnt != CW'(DEB - 1))   r_cnt <= r_cnt + 1'b1;
      if (w_accept) r_stable <= r_s2;
    end
  end

  assign o_stable = r_stable;
  assign o_set    = w_accept;
endmodule

module io_input_bank #(
  parameter int         N_PORTS  = 2,
  parameter int         PORT_W   = 5,
  parameter int         DIGITS   = 2,
  parameter logic [5:0] BASE_IDX = 6'b100000,
  parameter int         DEB_CYC  = 4
) (
  input  logic                          io_clk,
  input  logic                          resetn,
  io_input_bank_if.slave                bus,
  input  logic [N_PORTS*PORT_W-1:0]     in_port,
  output logic [N_PORTS*DIGITS*7-1:0]   dt,
  output logic                          bcd_busy
`ifdef IO_IN_IRQ_EN
  ,
  output logic                          io_irq
`endif
);
  localparam int         PW       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int         BW       = $clog2(PORT_W + 1);
  localparam logic [5:0] STAT_IDX = 6'(BASE_IDX + N_PORTS);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_WRITE} state_t;

  logic [N_PORTS-1:0][PORT_W-1:0]   w_stable;
  logic [N_PORTS-1:0]               w_set, w_change_nxt, r_change;
  logic [5:0]                       w_idx;
  logic                             w_st_rd;
  logic [31:0]                      w_rdata, r_io_data;
  logic                             w_unused_addr;

  state_t                           r_state;
  logic [PW-1:0]                    r_ptr;
  logic [BW-1:0]                    r_bit;
  logic [PORT_W-1:0]                r_sh;
  logic [19:0]                      r_acc, w_adj;  // 5 BCD nibbles cover 16-bit inputs
  logic                             r_busy;
  logic [N_PORTS-1:0][DIGITS-1:0][3:0] r_dig;

  genvar gi;
  generate
    for (gi = 0; gi < N_PORTS; gi++) begin : g_lane
      io_input_bank_lane #(.W(PORT_W), .DEB(DEB_CYC)) u_lane (
        .io_clk   (io_clk),
        .resetn   (resetn),
        .i_raw    (in_port[gi*PORT_W +: PORT_W]),
        .o_stable (w_stable[gi]),
        .o_set    (w_set[gi])
      );
    end
  endgenerate

  // ---------------- read path / status ----------------
  assign w_idx         = bus.addr[7:2];
  assign w_unused_addr = &{bus.addr[31:8], bus.addr[1:0]};
  assign w_st_rd       = bus.rd && (w_idx == STAT_IDX);
  // A set arriving in the clearing cycle survives.
  assign w_change_nxt  = (w_st_rd ? '0 : r_change) | w_set;

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < N_PORTS; i++)
      if (w_idx == 6'(BASE_IDX + i)) w_rdata = 32'(w_stable[i]);
    if (w_idx == STAT_IDX) w_rdata = 32'(r_change);
  end

  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_change  <= '0;
      r_io_data <= '0;
    end else begin
      r_change  <= w_change_nxt;
      r_io_data <= w_rdata;
    end
  end

  assign bus.io_data = r_io_data;

`ifdef IO_IN_IRQ_EN
  logic r_irq;
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) r_irq <= 1'b0;
    else         r_irq <= |w_change_nxt;
  end
  assign io_irq = r_irq;
`endif

  // ---------------- BCD engine ----------------
  always_comb begin
    w_adj = r_acc;
    for (int k = 0; k < 5; k++)
      if (r_acc[4*k +: 4] >= 4'd5) w_adj[4*k +: 4] = r_acc[4*k +: 4] + 4'd3;
  end

  // r_ptr names the port being converted; it advances on WRITE so the
  // first pass after reset starts at port 0.
  always_ff @(posedge io_clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_dig   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy  <= 1'b1;
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_sh    <= w_stable[r_ptr];
          r_acc   <= '0;
          r_bit   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          r_acc <= {w_adj[18:0], r_sh[PORT_W-1]};
          r_sh  <= r_sh << 1;
          r_bit <= r_bit + 1'b1;
          if (r_bit == BW'(PORT_W - 1)) r_state <= S_WRITE;
        end
        S_WRITE: begin
          r_dig[r_ptr] <= r_acc[4*DIGITS-1:0];  // drops digits above DIGITS
          r_ptr        <= (r_ptr == PW'(N_PORTS - 1)) ? '0 : r_ptr + 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bcd_busy = r_busy;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  always_comb begin
    dt = '0;
    for (int i = 0; i < N_PORTS; i++)
      for (int d = 0; d < DIGITS; d++)
        dt[(i*DIGITS+d)*7 +: 7] = seg7(r_dig[i][d]);
  end
endmodule
